// File: rtl/axi32_pkg.sv
// ---------------------------------------------------------------------------
// axi32_pkg
// Shared definitions for the AXI4-Lite master:
//   state_t      - master FSM state encoding
//   RESP_*       - AXI response codes (DECERR doubles as the timeout code)
//   DATAWIDTH    - the only supported AXI data width
//   sat_inc8     - 8-bit saturating increment
// ---------------------------------------------------------------------------
package axi32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DATAWIDTH = 32;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axi32_lite_master_if.sv
// ---------------------------------------------------------------------------
// axi32_lite_master_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) without clock/reset.
//   master modport : drives addr/data/strb/valid on AW/W/AR, ready on B/R
//   slave  modport : mirror image
// ---------------------------------------------------------------------------
interface axi32_lite_master_if
  import axi32_pkg::*;
#(
  parameter int addrwidth = 8,
  parameter int datawidth = DATAWIDTH
);
  logic [addrwidth-1:0]   awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [datawidth-1:0]   wdata;
  logic [datawidth/8-1:0] wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [addrwidth-1:0]   araddr;
  logic                   arvalid;
  logic                   arready;
  logic [datawidth-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi32_lite_master.sv
// ---------------------------------------------------------------------------
// axi32_lite_master
// Single-outstanding AXI4-Lite master. A command (read or write) is accepted
// in IDLE, run on the AXI bus, and answered with one response beat.
// A per-transaction wait counter aborts a stalled transaction after
// timeout_cycles cycles: all AXI valid/ready drop and the response carries
// DECERR plus the timeout flag. That abort is a debug recovery and is NOT
// AXI compliant (a slave may be left mid-handshake).
// Ports:
//   m_axi_clk_in, m_axi_reset_n_in  clock, async active-low reset
//   cmd_*                           command handshake + payload
//   rsp_*                           response handshake, rdata, resp, timeout
//   timeout_cnt_out                 saturating count of timed-out commands
//   m_axi                           AXI4-Lite master modport
// Only datawidth = 32 is supported.
// ---------------------------------------------------------------------------
module axi32_lite_master
  import axi32_pkg::*;
#(
  parameter int datawidth      = DATAWIDTH,
  parameter int addrwidth      = 8,
  parameter int timeout_cycles = 255
) (
  input  logic                   m_axi_clk_in,
  input  logic                   m_axi_reset_n_in,
  input  logic                   cmd_valid_in,
  output logic                   cmd_ready_out,
  input  logic                   cmd_write_in,
  input  logic [addrwidth-1:0]   cmd_addr_in,
  input  logic [datawidth-1:0]   cmd_wdata_in,
  input  logic [datawidth/8-1:0] cmd_wstrb_in,
  output logic                   rsp_valid_out,
  input  logic                   rsp_ready_in,
  output logic [datawidth-1:0]   rsp_rdata_out,
  output logic [1:0]             rsp_resp_out,
  output logic                   rsp_timeout_out,
  output logic [7:0]             timeout_cnt_out,
  axi32_lite_master_if.master    m_axi
);

  localparam logic [8:0] TMO_LIM = 9'(timeout_cycles);

  state_t                 state;
  logic [addrwidth-1:0]   addr_q;
  logic [datawidth-1:0]   wdata_q;
  logic [datawidth/8-1:0] wstrb_q;
  logic                   awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                   aw_done, w_done;
  logic [7:0]             wait_cnt;

  logic aw_hs, w_hs, expired, tmo;

  // Held low during reset so no command is offered until reset is released.
  assign cmd_ready_out = (state == ST_IDLE) & m_axi_reset_n_in;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign aw_hs   = awvalid_q & m_axi.awready;
  assign w_hs    = wvalid_q & m_axi.wready;
  // Fires in the cycle that would make the wait count reach the limit.
  assign expired = ({1'b0, wait_cnt} + 9'd1) >= TMO_LIM;

  // A handshake in the expiring cycle always takes precedence over the abort.
  always_comb begin
    tmo = 1'b0;
    case (state)
      ST_WR_REQ:  tmo = expired & ~aw_hs & ~w_hs;
      ST_WR_RESP: tmo = expired & ~m_axi.bvalid;
      ST_RD_REQ:  tmo = expired & ~m_axi.arready;
      ST_RD_DATA: tmo = expired & ~m_axi.rvalid;
      default:    tmo = 1'b0;
    endcase
  end

  always_ff @(posedge m_axi_clk_in or negedge m_axi_reset_n_in) begin
    if (!m_axi_reset_n_in) begin
      state           <= ST_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      bready_q        <= 1'b0;
      arvalid_q       <= 1'b0;
      rready_q        <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      wait_cnt        <= '0;
      rsp_valid_out   <= 1'b0;
      rsp_rdata_out   <= '0;
      rsp_resp_out    <= RESP_OKAY;
      rsp_timeout_out <= 1'b0;
      timeout_cnt_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_in) begin
            addr_q          <= cmd_addr_in;
            wdata_q         <= cmd_wdata_in;
            wstrb_q         <= cmd_wstrb_in;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            wait_cnt        <= '0;
            rsp_timeout_out <= 1'b0;
            if (cmd_write_in) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= ST_WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state     <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          wait_cnt <= sat_inc8(wait_cnt);
          // AW and W retire independently; leave once both are done.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            bready_q <= 1'b1;
            state    <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          wait_cnt <= sat_inc8(wait_cnt);
          if (m_axi.bvalid) begin
            bready_q      <= 1'b0;
            rsp_resp_out  <= m_axi.bresp;
            rsp_rdata_out <= '0;
            rsp_valid_out <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_RD_REQ: begin
          wait_cnt <= sat_inc8(wait_cnt);
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          wait_cnt <= sat_inc8(wait_cnt);
          if (m_axi.rvalid) begin
            rready_q      <= 1'b0;
            rsp_rdata_out <= m_axi.rdata;
            rsp_resp_out  <= m_axi.rresp;
            rsp_valid_out <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready_in) begin
            rsp_valid_out <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Timeout abort overrides whatever the state branch scheduled.
      if (tmo) begin
        awvalid_q       <= 1'b0;
        wvalid_q        <= 1'b0;
        bready_q        <= 1'b0;
        arvalid_q       <= 1'b0;
        rready_q        <= 1'b0;
        rsp_resp_out    <= RESP_DECERR;
        rsp_timeout_out <= 1'b1;
        rsp_rdata_out   <= '0;
        rsp_valid_out   <= 1'b1;
        timeout_cnt_out <= sat_inc8(timeout_cnt_out);
        state           <= ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_axi32_lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi32_lite_master
// Directed bench for axi32_lite_master (timeout_cycles = 8) with a small
// configurable-latency AXI4-Lite slave and a bus monitor.
// ---------------------------------------------------------------------------
module tb_axi32_lite_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_in, cmd_ready_out, cmd_write_in;
  logic [7:0]  cmd_addr_in;
  logic [31:0] cmd_wdata_in;
  logic [3:0]  cmd_wstrb_in;
  logic        rsp_valid_out, rsp_ready_in;
  logic [31:0] rsp_rdata_out;
  logic [1:0]  rsp_resp_out;
  logic        rsp_timeout_out;
  logic [7:0]  timeout_cnt_out;

  axi32_lite_master_if #(.addrwidth(8), .datawidth(32)) axi ();

  axi32_lite_master #(.datawidth(32), .addrwidth(8), .timeout_cycles(8)) dut (
    .m_axi_clk_in     (clk),
    .m_axi_reset_n_in (rst_n),
    .cmd_valid_in     (cmd_valid_in),
    .cmd_ready_out    (cmd_ready_out),
    .cmd_write_in     (cmd_write_in),
    .cmd_addr_in      (cmd_addr_in),
    .cmd_wdata_in     (cmd_wdata_in),
    .cmd_wstrb_in     (cmd_wstrb_in),
    .rsp_valid_out    (rsp_valid_out),
    .rsp_ready_in     (rsp_ready_in),
    .rsp_rdata_out    (rsp_rdata_out),
    .rsp_resp_out     (rsp_resp_out),
    .rsp_timeout_out  (rsp_timeout_out),
    .timeout_cnt_out  (timeout_cnt_out),
    .m_axi            (axi)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave configuration: readiness asserted on the Nth cycle valid/ready is seen.
  int          aw_lat = 1, w_lat = 1, b_lat = 1, ar_lat = 1, r_lat = 1;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = '0;

  initial begin
    int aw_n, w_n, b_n, ar_n, r_n;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (axi.awvalid) begin aw_n++; axi.awready = (aw_n >= aw_lat); end
      else begin aw_n = 0; axi.awready = 1'b0; end
      if (axi.wvalid) begin w_n++; axi.wready = (w_n >= w_lat); end
      else begin w_n = 0; axi.wready = 1'b0; end
      if (axi.arvalid) begin ar_n++; axi.arready = (ar_n >= ar_lat); end
      else begin ar_n = 0; axi.arready = 1'b0; end
      if (axi.bready) begin b_n++; axi.bvalid = (b_n >= b_lat); axi.bresp = s_bresp; end
      else begin b_n = 0; axi.bvalid = 1'b0; end
      if (axi.rready) begin
        r_n++; axi.rvalid = (r_n >= r_lat); axi.rdata = s_rdata; axi.rresp = s_rresp;
      end else begin r_n = 0; axi.rvalid = 1'b0; end
    end
  end

  // Bus monitor; cycle 1 is the first cycle after the command is captured.
  int          cyc, aw_hi, w_hi, ar_hi, b_rise, aw_first, w_first, aw_hs_cyc, w_hs_cyc;
  logic        prev_b;
  logic [31:0] m_awaddr, m_wdata, m_wstrb, m_araddr;

  task automatic clr_mon();
    cyc = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; b_rise = 0;
    aw_first = -1; w_first = -1; aw_hs_cyc = -1; w_hs_cyc = -1;
    m_awaddr = '1; m_wdata = '1; m_wstrb = '1; m_araddr = '1;
  endtask

  initial begin
    clr_mon();
    prev_b = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (axi.awvalid) begin
        aw_hi++;
        if (aw_first < 0) aw_first = cyc;
        if (axi.awready) begin aw_hs_cyc = cyc; m_awaddr = 32'(axi.awaddr); end
      end
      if (axi.wvalid) begin
        w_hi++;
        if (w_first < 0) w_first = cyc;
        if (axi.wready) begin w_hs_cyc = cyc; m_wdata = axi.wdata; m_wstrb = 32'(axi.wstrb); end
      end
      if (axi.arvalid) begin
        ar_hi++;
        if (axi.arready) m_araddr = 32'(axi.araddr);
      end
      if (axi.bready && !prev_b) b_rise++;
      prev_b = axi.bready;
    end
  end

  int          lat;
  logic [31:0] r_rdata;
  logic [1:0]  r_resp;
  logic        r_tmo;
  logic [7:0]  r_tcnt;

  task automatic run_cmd(input logic wr, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws);
    int n;
    cmd_write_in = wr; cmd_addr_in = addr; cmd_wdata_in = wd; cmd_wstrb_in = ws;
    cmd_valid_in = 1'b1;
    n = 0;
    while (!cmd_ready_out && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    clr_mon();
    lat = 1;
    while (!rsp_valid_out && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("rsp_valid_seen", 32'(rsp_valid_out), 32'd1);
    r_rdata = rsp_rdata_out; r_resp = rsp_resp_out;
    r_tmo = rsp_timeout_out; r_tcnt = timeout_cnt_out;
    rsp_ready_in = 1'b1;
    @(posedge clk); #1;
    rsp_ready_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid_in = 1'b0; cmd_write_in = 1'b0; cmd_addr_in = '0;
    cmd_wdata_in = '0; cmd_wstrb_in = '0; rsp_ready_in = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready_out), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
    chk("rst_rsp_resp", 32'(rsp_resp_out), 32'd0);
    chk("rst_rsp_tmo", 32'(rsp_timeout_out), 32'd0);
    chk("rst_tcnt", 32'(timeout_cnt_out), 32'd0);
    chk("rst_valids", 32'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_cmd_ready", 32'(cmd_ready_out), 32'd1);
    @(posedge clk); #1;

    // Write, slave ready immediately: AW and W in the same cycle, B OKAY
    aw_lat = 1; w_lat = 1; b_lat = 1; s_bresp = 2'b00;
    run_cmd(1'b1, 8'h04, 32'h0000_0003, 4'hF);
    chk("wr1_lat_le4", 32'(lat <= 4), 32'd1);
    chk("wr1_resp", 32'(r_resp), 32'd0);
    chk("wr1_aw_hs_cyc", 32'(aw_hs_cyc), 32'd1);
    chk("wr1_w_hs_cyc", 32'(w_hs_cyc), 32'd1);
    chk("wr1_awaddr", m_awaddr, 32'h04);
    chk("wr1_wdata", m_wdata, 32'h3);
    chk("wr1_wstrb", m_wstrb, 32'hF);

    // Read 0x00 with arready delayed 4 cycles
    ar_lat = 5; r_lat = 1; s_rdata = 32'h5446_0000; s_rresp = 2'b00;
    run_cmd(1'b0, 8'h00, 32'h0, 4'h0);
    chk("rd1_rdata", r_rdata, 32'h5446_0000);
    chk("rd1_resp", 32'(r_resp), 32'd0);
    chk("rd1_ar_hi", 32'(ar_hi), 32'd5);
    chk("rd1_araddr", m_araddr, 32'h00);

    // Write with awready at cycle 1, wready at cycle 3
    aw_lat = 1; w_lat = 3; b_lat = 1;
    run_cmd(1'b1, 8'h10, 32'hA5A5_0F0F, 4'h3);
    chk("wr2_start_same", 32'({aw_first[7:0], w_first[7:0]}), 32'h0101);
    chk("wr2_aw_hi", 32'(aw_hi), 32'd1);
    chk("wr2_w_hi", 32'(w_hi), 32'd3);
    chk("wr2_b_phases", 32'(b_rise), 32'd1);
    chk("wr2_resp", 32'(r_resp), 32'd0);
    chk("wr2_rdata_zero", r_rdata, 32'h0);
    chk("wr2_wstrb", m_wstrb, 32'h3);
    chk("wr2_wdata", m_wdata, 32'hA5A5_0F0F);

    // Read where arready never comes: timeout after 8 cycles
    ar_lat = 1000;
    run_cmd(1'b0, 8'h20, 32'h0, 4'h0);
    chk("tmo_ar_hi", 32'(ar_hi), 32'd8);
    chk("tmo_resp", 32'(r_resp), 32'd3);
    chk("tmo_flag", 32'(r_tmo), 32'd1);
    chk("tmo_cnt", 32'(r_tcnt), 32'd1);
    chk("tmo_rdata", r_rdata, 32'h0);

    // Read 0x0C with rresp 11: error response, timeout flag cleared
    ar_lat = 1; r_lat = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b11;
    run_cmd(1'b0, 8'h0C, 32'h0, 4'h0);
    chk("rderr_resp", 32'(r_resp), 32'd3);
    chk("rderr_tmo", 32'(r_tmo), 32'd0);
    chk("rderr_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("rderr_cnt", 32'(r_tcnt), 32'd1);

    // arready on the last allowed cycle: handshake wins over the timeout
    ar_lat = 8; r_lat = 1; s_rdata = 32'h1234_5678; s_rresp = 2'b00;
    run_cmd(1'b0, 8'h08, 32'h0, 4'h0);
    chk("edge_resp", 32'(r_resp), 32'd0);
    chk("edge_tmo", 32'(r_tmo), 32'd0);
    chk("edge_rdata", r_rdata, 32'h1234_5678);
    chk("edge_cnt", 32'(r_tcnt), 32'd1);

    // Write whose B never arrives: timeout in WR_RESP
    aw_lat = 1; w_lat = 1; b_lat = 1000;
    run_cmd(1'b1, 8'h14, 32'h1, 4'h1);
    chk("wtmo_resp", 32'(r_resp), 32'd3);
    chk("wtmo_flag", 32'(r_tmo), 32'd1);
    chk("wtmo_cnt", 32'(r_tcnt), 32'd2);
    chk("wtmo_bready_low", 32'(axi.bready), 32'd0);

    // Timeout counter saturation
    ar_lat = 1000;
    for (int i = 0; i < 256; i++) run_cmd(1'b0, 8'h30, 32'h0, 4'h0);
    chk("tcnt_sat", 32'(r_tcnt), 32'd255);

    // Reset asserted during WR_RESP
    aw_lat = 1; w_lat = 1; b_lat = 1000;
    cmd_write_in = 1'b1; cmd_addr_in = 8'h44; cmd_wdata_in = 32'h55; cmd_wstrb_in = 4'hF;
    cmd_valid_in = 1'b1;
    @(posedge clk); #1;
    cmd_valid_in = 1'b0;
    for (int i = 0; i < 10 && !axi.bready; i++) begin @(posedge clk); #1; end
    chk("rst_mid_in_wr_resp", 32'(axi.bready), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_valids", 32'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid_out), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready_out), 32'd0);
    chk("rst_mid_tcnt", 32'(timeout_cnt_out), 32'd0);
    chk("rst_mid_awaddr", 32'(axi.awaddr), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel2_cmd_ready", 32'(cmd_ready_out), 32'd1);
    @(posedge clk); #1;
    chk("rel2_rsp_valid", 32'(rsp_valid_out), 32'd0);
    chk("rel2_cmd_ready_hold", 32'(cmd_ready_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi32_lite_master.md
AXI32_LITE_MASTER -- requirements
Module: axi32_lite_master

Interface
REQ-001 Parameter datawidth, default 32, AXI data width; only 32 supported.
REQ-002 Parameter addrwidth, default 8, AXI byte-address width.
REQ-003 Parameter timeout_cycles, default 255, wait-state limit per transaction, range 1..255.
REQ-004 m_axi_clk_in  input  1  single clock, all logic rising-edge.
REQ-005 m_axi_reset_n_in  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid_in / cmd_ready_out  in/out  1/1  command handshake.
REQ-007 cmd_write_in  input  1  1 means write, 0 means read.
REQ-008 cmd_addr_in / cmd_wdata_in / cmd_wstrb_in  input  addrwidth/32/4  command payload.
REQ-009 rsp_valid_out / rsp_ready_in  out/in  1/1  response handshake.
REQ-010 rsp_rdata_out / rsp_resp_out / rsp_timeout_out  output  32/2/1  read data, AXI response, timeout flag.
REQ-011 m_axi_aw{addr,valid,ready}, m_axi_w{data,strb,valid,ready}, m_axi_b{resp,valid,ready}, m_axi_ar{addr,valid,ready}, m_axi_r{data,resp,valid,ready}  AXI4-Lite master  standard directions and widths.
REQ-012 timeout_cnt_out  output  8  saturating count of timed-out transactions.

Function
REQ-013 FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
REQ-014 cmd_ready_out = 1 only in IDLE; a handshake captures the whole payload into registers and moves to WR_REQ (write) or RD_REQ (read).
REQ-015 In WR_REQ, awvalid and wvalid assert together on the first cycle.
REQ-016 Each of awvalid and wvalid drops the cycle after its own ready is sampled high, independently of the other.
REQ-017 The FSM moves to WR_RESP only after both the AW and W handshakes have completed, in either order or in the same cycle.
REQ-018 In WR_RESP, bready = 1; on bvalid, bresp is captured, rsp_rdata = 0, and the FSM moves to DONE.
REQ-019 In RD_REQ, arvalid = 1 until arready; then RD_DATA with rready = 1.
REQ-020 In RD_DATA, on rvalid, rdata and rresp are captured and the FSM moves to DONE.
REQ-021 AXI address, data and strobe outputs come from the captured registers and stay stable while valid is high.
REQ-022 In DONE, rsp_valid_out = 1 and holds until rsp_ready_in; then IDLE. Minimum command-to-command spacing is one idle cycle.
REQ-023 A wait counter clears on entry to WR_REQ/RD_REQ and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
REQ-024 When the counter reaches timeout_cycles: all AXI valid/ready outputs drop, rsp_resp = 2'b11, rsp_timeout = 1, rsp_rdata = 0, and the FSM enters DONE. This is a debug recovery and is documented as AXI non-compliant.
REQ-025 timeout_cnt_out increments on each timeout and saturates at 255.
REQ-026 If a handshake and the timeout occur in the same cycle, the handshake wins and no timeout is recorded.
REQ-027 rsp_timeout is cleared on the next command capture.

Reset
REQ-028 Reset asserted: FSM = IDLE; all AXI valid/ready = 0; cmd_ready = 0 while in reset, 1 in the first cycle after release; rsp_valid = 0; rsp_rdata = 0; rsp_resp = 0; rsp_timeout = 0; timeout_cnt = 0; captured registers = 0.
REQ-029 Reset mid-transaction aborts immediately with no response issued; the downstream slave is expected to share the same reset.

Structure
REQ-030 Package axi32_pkg holds the FSM state encoding, the AXI response codes (OKAY 00, SLVERR 10, DECERR/timeout 11) and the datawidth constant.
REQ-031 The block is one module with no sub-modules; the wait counter is inline.
REQ-032 Output ports are driven from registers except cmd_ready_out, which decodes the registered FSM state.

Verification
REQ-033 Write addr 0x04, data 0x00000003, strb 0xF, slave ready immediately -> AW and W handshake on the same cycle, B OKAY, rsp_resp 00, rsp_valid 1 within 4 cycles.
REQ-034 Read addr 0x00, slave returns 0x54460000 after arready delayed 4 cycles -> rsp_rdata 0x54460000, rsp_resp 00.
REQ-035 Write with awready at cycle 1 and wready at cycle 3 -> awvalid low from cycle 2, wvalid low from cycle 4, single bready phase.
REQ-036 Read addr 0x0C, slave returns rresp 11 -> rsp_resp 11, rsp_timeout 0.
REQ-037 timeout_cycles = 8, slave never asserts arready -> arvalid drops at cycle 8, rsp_resp 11, rsp_timeout 1, timeout_cnt 1.
REQ-038 Reset asserted during WR_RESP -> all valids low asynchronously, no rsp_valid, cmd_ready 1 in the first cycle after release.
